// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/add/sub, iterative shifts (SHIFT_STEP bits per cycle),
// valid/ready on both sides with a registered result and zero flag.
module alu_exec_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  localparam int unsigned SW = $clog2(XLEN);
  localparam logic [SW-1:0] StepW = SW'(SHIFT_STEP);

  localparam logic [3:0] CtrlAnd = 4'b0000;
  localparam logic [3:0] CtrlOr  = 4'b0001;
  localparam logic [3:0] CtrlAdd = 4'b0010;
  localparam logic [3:0] CtrlSub = 4'b0110;
  localparam logic [3:0] CtrlSll = 4'b1000;
  localparam logic [3:0] CtrlSrl = 4'b1001;
  localparam logic [3:0] CtrlSra = 4'b1010;

  generate
    if (SHIFT_STEP < 1 || SHIFT_STEP > XLEN / 2 || (SHIFT_STEP & (SHIFT_STEP - 1)) != 0) begin : g_bad_step
      $error("SHIFT_STEP must be a power of two in 1..XLEN/2");
    end
  endgenerate

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [1:0] {ShSll, ShSrl, ShSra} shop_e;

  state_e          r_state, w_state_nxt;
  shop_e           r_shop, w_shop_nxt;
  logic [XLEN-1:0] r_result, w_result_nxt;
  logic [SW-1:0]   r_remaining, w_remaining_nxt;
  logic            r_zero;
  logic            r_illegal, w_illegal_nxt;
  logic            w_load;
  logic            w_accept;
  logic [SW-1:0]   w_shamt;
  logic [SW-1:0]   w_step;
  logic [SW-1:0]   w_rem_after;
  logic [XLEN-1:0] w_shifted;

  assign w_accept  = in_valid && in_ready;
  assign w_shamt   = op_b[SW-1:0];
  assign in_ready  = (r_state == StIdle) && !flush;
  assign out_valid = (r_state == StDone) && !flush;
  assign busy      = (r_state != StIdle);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

  // Each SHIFT cycle moves by min(SHIFT_STEP, remaining).
  always_comb begin
    w_step      = (r_remaining < StepW) ? r_remaining : StepW;
    w_rem_after = r_remaining - w_step;
    w_shifted   = r_result;
    unique case (r_shop)
      ShSll:   w_shifted = r_result << w_step;
      ShSrl:   w_shifted = r_result >> w_step;
      ShSra:   w_shifted = $unsigned($signed(r_result) >>> w_step);
      default: w_shifted = r_result;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_shop_nxt      = r_shop;
    w_result_nxt    = r_result;
    w_remaining_nxt = r_remaining;
    w_illegal_nxt   = r_illegal;
    w_load          = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_load        = 1'b1;
          w_illegal_nxt = 1'b0;
          w_state_nxt   = StDone;
          case (alu_ctrl)
            CtrlAnd: w_result_nxt = op_a & op_b;
            CtrlOr:  w_result_nxt = op_a | op_b;
            CtrlAdd: w_result_nxt = op_a + op_b;
            CtrlSub: w_result_nxt = op_a - op_b;
            CtrlSll, CtrlSrl, CtrlSra: begin
              w_result_nxt    = op_a;
              w_remaining_nxt = w_shamt;
              w_shop_nxt      = (alu_ctrl == CtrlSll) ? ShSll :
                                (alu_ctrl == CtrlSrl) ? ShSrl : ShSra;
              if (w_shamt != '0) w_state_nxt = StShift;
            end
            default: begin
              w_result_nxt  = '0;
              w_illegal_nxt = 1'b1;
            end
          endcase
        end
      end
      StShift: begin
        w_load          = 1'b1;
        w_result_nxt    = w_shifted;
        w_remaining_nxt = w_rem_after;
        if (w_rem_after == '0) w_state_nxt = StDone;
      end
      StDone: begin
        if (out_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase

    if (flush) w_state_nxt = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_shop      <= ShSll;
      r_result    <= '0;
      r_remaining <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shop      <= w_shop_nxt;
      r_remaining <= w_remaining_nxt;
      r_illegal   <= w_illegal_nxt;
      // zero tracks result only when result itself is written.
      if (w_load) begin
        r_result <= w_result_nxt;
        r_zero   <= (w_result_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: two instances (SHIFT_STEP 1 and 2) share stimulus so shift
// latencies can be compared side by side.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b;
  logic        in_ready, out_valid, zero, illegal, busy;
  logic [31:0] result;
  logic        in_ready2, out_valid2, zero2, illegal2, busy2;
  logic [31:0] result2;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  int busy_gaps;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal), .busy(busy)
  );

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid2),
    .out_ready(out_ready), .result(result2), .zero(zero2), .illegal(illegal2), .busy(busy2)
  );

  always @(posedge clk) if (out_valid && out_ready) hs_count++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one op, then count cycles from the accept edge until each instance shows out_valid.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int l1, output int l2);
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    l1        = 0;
    l2        = 0;
    busy_gaps = 0;
    for (int n = 1; n <= 100; n++) begin
      if (l1 == 0 && out_valid) l1 = n;
      if (l2 == 0 && out_valid2) l2 = n;
      if (l1 == 0 && !busy) busy_gaps++;
      if (l1 != 0 && l2 != 0) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  int l1, l2, hs_before;
  logic [31:0] held;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = 4'h0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_zero", zero, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted mid-shift.
    alu_ctrl = 4'b1000; op_a = 32'h1; op_b = 32'd31; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check_eq("midshift_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_result", result, 0);
    check_eq("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(4'b0010, 32'd3, 32'd4, l1, l2);
    check_eq("add_lat", l1, 1);
    check_eq("add_res", result, 32'd7);
    hs_before = hs_count;
    handshake();
    check_eq("add_hs", hs_count - hs_before, 1);
    check_eq("add_drop", out_valid, 0);

    run_op(4'b0010, 32'hFFFF_FFFF, 32'h1, l1, l2);
    check_eq("addwrap_lat", l1, 1);
    check_eq("addwrap_res", result, 32'h0);
    check_eq("addwrap_zero", zero, 1);
    check_eq("addwrap_ill", illegal, 0);
    handshake();

    run_op(4'b0110, 32'd5, 32'd7, l1, l2);
    check_eq("sub_res", result, 32'hFFFF_FFFE);
    check_eq("sub_zero", zero, 0);
    handshake();

    run_op(4'b1010, 32'h8000_0000, 32'h24, l1, l2);
    check_eq("sra_lat1", l1, 5);
    check_eq("sra_lat2", l2, 3);
    check_eq("sra_res1", result, 32'hF800_0000);
    check_eq("sra_res2", result2, 32'hF800_0000);
    handshake();

    run_op(4'b1001, 32'h8000_0000, 32'h24, l1, l2);
    check_eq("srl_lat1", l1, 5);
    check_eq("srl_res1", result, 32'h0800_0000);
    check_eq("srl_res2", result2, 32'h0800_0000);
    handshake();

    run_op(4'b1000, 32'h1234, 32'h40, l1, l2);
    check_eq("sll0_lat", l1, 1);
    check_eq("sll0_res", result, 32'h1234);
    handshake();

    run_op(4'b1000, 32'h1, 32'd31, l1, l2);
    check_eq("sll31_lat1", l1, 32);
    check_eq("sll31_lat2", l2, 17);
    check_eq("sll31_busy_gaps", busy_gaps, 0);
    check_eq("sll31_res", result, 32'h8000_0000);
    check_eq("sll31_res2", result2, 32'h8000_0000);
    handshake();

    run_op(4'b1111, 32'h55, 32'h66, l1, l2);
    check_eq("ill_f_lat", l1, 1);
    check_eq("ill_f_res", result, 0);
    check_eq("ill_f_zero", zero, 1);
    check_eq("ill_f_flag", illegal, 1);
    handshake();

    run_op(4'b0011, 32'h55, 32'h66, l1, l2);
    check_eq("ill_3_res", result, 0);
    check_eq("ill_3_zero", zero, 1);
    check_eq("ill_3_flag", illegal, 1);
    handshake();

    run_op(4'b0000, 32'hF0F0, 32'hFF00, l1, l2);
    check_eq("and_res", result, 32'hF000);
    check_eq("and_ill", illegal, 0);
    check_eq("and_zero", zero, 0);
    handshake();

    // Backpressure: result held, no new accept.
    run_op(4'b0001, 32'h0F, 32'hF0, l1, l2);
    held = result;
    check_eq("or_res", held, 32'hFF);
    in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd1; op_b = 32'd1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("bp_result", result, 32'hFF);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    handshake();
    check_eq("bp_after_idle", busy, 0);
    check_eq("bp_after_res", result, 32'hFF);

    // Flush during DONE dominates out_ready.
    run_op(4'b0001, 32'h1, 32'h2, l1, l2);
    hs_before = hs_count;
    out_ready = 1'b1; flush = 1'b1;
    #1;
    check_eq("flush_out_valid", out_valid, 0);
    check_eq("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    check_eq("flush_busy", busy, 0);
    check_eq("flush_no_hs", hs_count - hs_before, 0);

    // Flush with in_valid in IDLE: nothing accepted.
    flush = 1'b1; in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flushacc_busy", busy, 0);
    @(posedge clk); #1;
    check_eq("flushacc_out_valid", out_valid, 0);
    check_eq("flushacc_result", result, 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
